tick_decoder: RTL
=================

TICK_DECODER -- requirements
Module: tick_decoder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on each toggle input, legal range 2..4.
REQ-002 SHALL have parameter TIMEOUT, default 4194304: clk cycles with no tick8x edge before a stall is declared.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is clocked on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port tick_in, input, 1 bit: slow toggle level; each transition is one game tick.
REQ-006 SHALL have port tick8x_in, input, 1 bit: fast toggle level; 8 transitions per tick_in transition.
REQ-007 SHALL have port enable, input, 1 bit: decode enable.
REQ-008 SHALL have port clear_err, input, 1 bit: clears sync_err.
REQ-009 SHALL have port tick, output, 1 bit: one-cycle strobe per tick_in transition.
REQ-010 SHALL have port tick8x, output, 1 bit: one-cycle strobe per tick8x_in transition.
REQ-011 SHALL have port phase, output, 3 bits: index of the current sub-tick since the last tick.
REQ-012 SHALL have port tick_count, output, 16 bits: number of ticks decoded.
REQ-013 SHALL have port locked, output, 1 bit: high in state LOCKED.
REQ-014 SHALL have port sync_err, output, 1 bit: sticky tick/sub-tick misalignment flag.
REQ-015 SHALL have port stall, output, 1 bit: high in state STALLED.

Function
REQ-016 Each input SHALL pass SYNC_STAGES flops, then a previous-value register; an edge is the XOR of the synchronized value and the previous value.
REQ-017 A level change present before clk edge 0 SHALL produce its strobe, registered, high for exactly the one cycle following edge SYNC_STAGES.
REQ-018 Strobes SHALL be suppressed for the first SYNC_STAGES+1 cycles after reset (priming), so a high input at reset creates no strobe.
REQ-019 States SHALL be UNLOCKED (the reset state), LOCKED and STALLED.
REQ-020 A tick8x edge without a tick edge SHALL increment phase, wrapping 7->0.
REQ-021 A tick edge SHALL set phase to 0 and increment tick_count, wrapping 0xFFFF->0.
REQ-022 In UNLOCKED, a tick edge SHALL move the state to LOCKED with no error check.
REQ-023 In LOCKED, a tick edge with no simultaneous tick8x edge, or with phase != 7, SHALL set sync_err; the state stays LOCKED.
REQ-024 When clear_err and a new error coincide in the same cycle, the new error SHALL win and sync_err is set.
REQ-025 While enable is low: the previous-value registers keep updating, strobes are forced to 0, phase and tick_count hold, and the state goes to UNLOCKED.

Reset
REQ-026 rst_n low SHALL asynchronously clear all flops, setting tick=0, tick8x=0, phase=0, tick_count=0, locked=0, sync_err=0, stall=0, state UNLOCKED, and restarting priming.
REQ-027 Reset asserted mid-tick SHALL discard any partial phase; the first tick after release SHALL not raise sync_err.

Configuration
REQ-028 Macro TICK_DECODER_WATCHDOG_EN SHALL compile in the watchdog.
REQ-029 With the macro defined:
- a 23-bit counter counts cycles while enable is high and clears on every tick8x edge and whenever enable is low;
- when the count reaches TIMEOUT, the state SHALL move to STALLED;
- in STALLED, the next tick edge SHALL move the state to UNLOCKED;
- a tick8x edge in the same cycle as reaching TIMEOUT SHALL prevent the stall.
REQ-030 Without the macro, stall SHALL be tied to 0, no watchdog counter exists, and STALLED is unreachable.

Verification
Bench setup: SYNC_STAGES=2, TIMEOUT=64.
REQ-031 Toggle tick_in once with enable=1 -> tick high exactly 1 cycle, 3 edges after the change; tick_count 0->1; locked=1.
REQ-032 Hold tick_in=1 through reset and release -> no tick strobe during priming; tick_count stays 0.
REQ-033 After lock, apply 7 tick8x toggles, then toggle tick_in and tick8x_in together -> phase steps 1..7 then 0; sync_err=0.
REQ-034 After lock, toggle tick_in when phase=5 -> sync_err=1; phase=0; pulsing clear_err -> sync_err=0.
REQ-035 With TICK_DECODER_WATCHDOG_EN defined, after lock hold tick8x_in static for 64 cycles -> stall=1, locked=0; the next tick toggle -> stall=0, state UNLOCKED.
REQ-036 Drive 65536 tick toggles -> tick_count wraps to 0x0000.

Source files
------------

// File: rtl/tick_decoder.sv
// Tick / sub-tick decoder: synchronises two toggle inputs, emits strobes, tracks phase and lock.
// Optional stall watchdog compiled in with TICK_DECODER_WATCHDOG_EN.
//
// state    | meaning
// UNLOCKED | waiting for the first tick edge, no alignment check
// LOCKED   | ticks checked against phase 7 + coincident sub-tick
// STALLED  | sub-tick stream stopped for TIMEOUT cycles, next tick unlocks

module tick_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 4194304
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_in,
    input  logic        tick8x_in,
    input  logic        enable,
    input  logic        clear_err,
    output logic        tick,
    output logic        tick8x,
    output logic [2:0]  phase,
    output logic [15:0] tick_count,
    output logic        locked,
    output logic        sync_err,
    output logic        stall
);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED   = 2'd1,
        STALLED  = 2'd2
    } state_t;

    localparam logic [2:0] PRIME_CYC = 3'(SYNC_STAGES + 1);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TIMEOUT < 1 || TIMEOUT > 8388607) begin : g_param_check
        $error("tick_decoder: parameter out of range");
    end

    logic [SYNC_STAGES-1:0] tick_sync;
    logic [SYNC_STAGES-1:0] t8_sync;
    logic                   tick_prev;
    logic                   t8_prev;
    logic [2:0]             prime_cnt;
    logic                   primed;
    logic                   tick_e;
    logic                   t8_e;
    logic                   wd_hit;
    logic                   err_set;
    state_t                 state;
    state_t                 state_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_sync <= '0;
            t8_sync   <= '0;
            tick_prev <= 1'b0;
            t8_prev   <= 1'b0;
            prime_cnt <= 3'd0;
        end else begin
            tick_sync <= {tick_sync[SYNC_STAGES-2:0], tick_in};
            t8_sync   <= {t8_sync[SYNC_STAGES-2:0], tick8x_in};
            tick_prev <= tick_sync[SYNC_STAGES-1];
            t8_prev   <= t8_sync[SYNC_STAGES-1];
            if (prime_cnt != PRIME_CYC) begin
                prime_cnt <= prime_cnt + 3'd1;
            end
        end
    end

    // Priming hides the edge a non-zero input level would fake right after reset.
    assign primed = (prime_cnt == PRIME_CYC);
    assign tick_e = (tick_sync[SYNC_STAGES-1] ^ tick_prev) & enable & primed;
    assign t8_e   = (t8_sync[SYNC_STAGES-1] ^ t8_prev) & enable & primed;

`ifdef TICK_DECODER_WATCHDOG_EN
    localparam logic [22:0] WD_LIMIT = 23'(TIMEOUT);

    logic [22:0] wd_cnt;
    logic [22:0] wd_next;

    always_comb begin
        wd_next = wd_cnt;
        if (!enable || t8_e) begin
            wd_next = '0;
        end else if (wd_cnt != WD_LIMIT) begin
            wd_next = wd_cnt + 23'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_next;
        end
    end

    // A sub-tick edge in the limit cycle zeroes wd_next, so it cannot stall.
    assign wd_hit = (wd_next == WD_LIMIT);
`else
    assign wd_hit = 1'b0;
`endif

    always_comb begin
        state_next = state;
        err_set    = 1'b0;
        if (!enable) begin
            state_next = UNLOCKED;
        end else begin
            case (state)
                UNLOCKED: begin
                    if (tick_e) state_next = LOCKED;
                end
                LOCKED: begin
                    if (tick_e && (!t8_e || phase != 3'd7)) err_set = 1'b1;
                    if (wd_hit) state_next = STALLED;
                end
                STALLED: begin
                    if (tick_e) state_next = UNLOCKED;
                end
                default: state_next = UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= UNLOCKED;
            tick       <= 1'b0;
            tick8x     <= 1'b0;
            phase      <= 3'd0;
            tick_count <= 16'd0;
            sync_err   <= 1'b0;
        end else begin
            state  <= state_next;
            tick   <= tick_e;
            tick8x <= t8_e;
            if (tick_e) begin
                phase      <= 3'd0;
                tick_count <= tick_count + 16'd1;
            end else if (t8_e) begin
                phase <= phase + 3'd1;
            end
            if (err_set) begin
                sync_err <= 1'b1;
            end else if (clear_err) begin
                sync_err <= 1'b0;
            end
        end
    end

    assign locked = (state == LOCKED);

`ifdef TICK_DECODER_WATCHDOG_EN
    assign stall = (state == STALLED);
`else
    assign stall = 1'b0;
`endif

endmodule
